// File: rtl/picorv32_mul_pkg.sv
// picorv32_mul_pkg
// Shared constants and types for the pipelined PCPI multiplier.
//   - RV32M decode constants (opcode, funct7, funct3 values)
//   - mul_state_t : controller state encoding
//   - mul_cache_t : product-reuse cache entry, sized for the widest XLEN so
//                   one type serves every parameterisation of the top level
package picorv32_mul_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // Widest supported operand width; cache fields are zero-extended to this.
  localparam int XLEN_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic                    valid;
    logic [XLEN_MAX-1:0]     rs1;
    logic [XLEN_MAX-1:0]     rs2;
    logic                    rs1_signed;
    logic                    rs2_signed;
    logic [2*XLEN_MAX-1:0]   product;
  } mul_cache_t;

endpackage

// File: rtl/picorv32_pcpi_mul_pipe_if.sv
// picorv32_pcpi_mul_pipe_if
// PCPI request/response bundle between the core (master) and the multiplier
// coprocessor (slave).
//   request : pcpi_valid, pcpi_insn[31:0], pcpi_rs1/pcpi_rs2[XLEN-1:0]
//   response: pcpi_wr, pcpi_rd[XLEN-1:0], pcpi_wait, pcpi_ready, stat_hit
interface picorv32_pcpi_mul_pipe_if #(
  parameter int XLEN = 32
);

  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_wait;
  logic            pcpi_ready;
  logic            stat_hit;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, stat_hit
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, stat_hit
  );

endinterface

// File: rtl/picorv32_mul_core.sv
// picorv32_mul_core
// Signed (XLEN+1)x(XLEN+1) multiplier followed by MUL_STAGES retiming
// registers, with a matching valid shift chain.
//   clk, reset  : clock, synchronous active-high reset (clears valids)
//   flush       : synchronous; drops every in-flight stage
//   in_valid    : launch strobe for a, b
//   a, b        : sign/zero-extended operands (XLEN+1 bits, two's complement)
//   out_valid   : final stage holds a product
//   product     : low 2*XLEN bits of a*b
// The multiply is written ahead of the register chain so synthesis can
// retime it across the stages.
module picorv32_mul_core #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [XLEN:0]     a,
  input  logic [XLEN:0]     b,
  output logic              out_valid,
  output logic [2*XLEN-1:0] product
);

  // Sign-extending to 2*XLEN bits is enough: only the low 2*XLEN bits of the
  // product are ever used, and those are identical modulo 2^(2*XLEN).
  logic signed [2*XLEN-1:0] a_x;
  logic signed [2*XLEN-1:0] b_x;
  logic signed [2*XLEN-1:0] full;

  assign a_x  = {{(XLEN-1){a[XLEN]}}, a};
  assign b_x  = {{(XLEN-1){b[XLEN]}}, b};
  assign full = a_x * b_x;

  genvar gi;
  generate
    for (gi = 0; gi < MUL_STAGES; gi++) begin : g_stage
      logic              v_in;
      logic              v_q;
      logic [2*XLEN-1:0] d_in;
      logic [2*XLEN-1:0] d_q;

      if (gi == 0) begin : g_first
        assign v_in = in_valid;
        assign d_in = full;
      end else begin : g_next
        assign v_in = g_stage[gi-1].v_q;
        assign d_in = g_stage[gi-1].d_q;
      end

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          v_q <= 1'b0;
        end else begin
          v_q <= v_in;
        end
        if (v_in) begin
          d_q <= d_in;
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[MUL_STAGES-1].v_q;
  assign product   = g_stage[MUL_STAGES-1].d_q;

endmodule

// File: rtl/picorv32_pcpi_mul_pipe.sv
// picorv32_pcpi_mul_pipe
// PCPI coprocessor for RV32M MUL/MULH/MULHSU/MULHU on a pipelined multiplier,
// with a one-entry product-reuse cache and abort-on-withdraw.
//   clk    : clock
//   reset  : synchronous active-high; clears FSM, pipeline and cache valid
//   bus    : PCPI slave port (request in, wr/rd/wait/ready/stat_hit out)
// Parameters: XLEN (32/64), MUL_STAGES (1..4), ENABLE_REUSE, ENABLE_WAIT.
// Latency: miss -> ready MUL_STAGES+1 cycles after acceptance; hit -> 1 cycle.
module picorv32_pcpi_mul_pipe
  import picorv32_mul_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int MUL_STAGES   = 2,
  parameter bit ENABLE_REUSE = 1'b1,
  parameter bit ENABLE_WAIT  = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  picorv32_pcpi_mul_pipe_if.slave  bus
);

  localparam logic [2:0] CNT_INIT = 3'(MUL_STAGES);

  // ---------------------------------------------------------------- decode
  logic [2:0]  funct3;
  logic        decoded;
  logic        req;
  logic        rs1_signed;
  logic        rs2_signed;
  logic [XLEN:0] rs1_ext;
  logic [XLEN:0] rs2_ext;

  assign funct3  = bus.pcpi_insn[14:12];
  // funct3[2]=0 selects the four multiply forms of the MULDIV group.
  assign decoded = (bus.pcpi_insn[6:0] == OPCODE_OP) &&
                   (bus.pcpi_insn[31:25] == FUNCT7_MULDIV) &&
                   !bus.pcpi_insn[14];
  assign req     = bus.pcpi_valid && decoded;

  assign rs1_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
  assign rs2_signed = (funct3 == F3_MULH);
  assign rs1_ext    = {rs1_signed & bus.pcpi_rs1[XLEN-1], bus.pcpi_rs1};
  assign rs2_ext    = {rs2_signed & bus.pcpi_rs2[XLEN-1], bus.pcpi_rs2};

  logic unused_insn;
  assign unused_insn = ^{bus.pcpi_insn[24:15], bus.pcpi_insn[11:7]};

  // ----------------------------------------------------------------- state
  mul_state_t      state_reg;
  mul_state_t      state_next;
  logic [2:0]      cnt_reg;
  mul_cache_t      cache_reg;
  logic [XLEN-1:0] op_rs1_reg;
  logic [XLEN-1:0] op_rs2_reg;
  logic            op_rs1_signed_reg;
  logic            op_rs2_signed_reg;
  logic [2:0]      op_f3_reg;
  logic [XLEN-1:0] rd_reg;
  logic            ready_reg;
  logic            hit_reg;

  logic              core_valid;
  logic [2*XLEN-1:0] core_product;

  logic hit;
  logic launch;
  logic finish;
  logic flush;
  logic take_hit;

  // The low word does not depend on operand signedness, so MUL may reuse a
  // product computed for any MULH* form; the high forms need identical flags.
  assign hit = ENABLE_REUSE && cache_reg.valid &&
               (cache_reg.rs1 == XLEN_MAX'(bus.pcpi_rs1)) &&
               (cache_reg.rs2 == XLEN_MAX'(bus.pcpi_rs2)) &&
               ((funct3 == F3_MUL) ||
                ((cache_reg.rs1_signed == rs1_signed) &&
                 (cache_reg.rs2_signed == rs2_signed)));

  if (XLEN < XLEN_MAX) begin : g_cache_pad
    logic unused_cache_pad;
    assign unused_cache_pad = ^cache_reg.product[2*XLEN_MAX-1:2*XLEN];
  end

  function automatic logic [XLEN-1:0] pick(input logic [2*XLEN-1:0] p,
                                           input logic [2:0]        f3);
    return (f3 == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // ------------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    finish     = 1'b0;
    flush      = 1'b0;
    take_hit   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            state_next = ST_DONE;
            take_hit   = 1'b1;
          end else begin
            state_next = ST_BUSY;
            launch     = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // Withdrawal (trap/IRQ) takes priority over a completing product.
        if (!bus.pcpi_valid) begin
          state_next = ST_IDLE;
          flush      = 1'b1;
        end else if (core_valid && (cnt_reg == 3'd1)) begin
          state_next = ST_DONE;
          finish     = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      cache_reg <= '0;
      rd_reg    <= '0;
      ready_reg <= 1'b0;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= finish | take_hit;
      hit_reg   <= take_hit;

      if (finish) begin
        rd_reg <= pick(core_product, op_f3_reg);
      end else if (take_hit) begin
        rd_reg <= pick(cache_reg.product[2*XLEN-1:0], funct3);
      end else begin
        rd_reg <= '0;
      end

      if (launch) begin
        cnt_reg <= CNT_INIT;
      end else if ((state_reg == ST_BUSY) && (cnt_reg != 3'd0)) begin
        cnt_reg <= cnt_reg - 3'd1;
      end

      if (finish) begin
        cache_reg.valid      <= 1'b1;
        cache_reg.rs1        <= XLEN_MAX'(op_rs1_reg);
        cache_reg.rs2        <= XLEN_MAX'(op_rs2_reg);
        cache_reg.rs1_signed <= op_rs1_signed_reg;
        cache_reg.rs2_signed <= op_rs2_signed_reg;
        cache_reg.product    <= (2*XLEN_MAX)'(core_product);
      end
    end
  end

  // Operand register: remembers the launched request for result selection
  // and for tagging the cache entry when the product arrives.
  always_ff @(posedge clk) begin
    if (launch) begin
      op_rs1_reg        <= bus.pcpi_rs1;
      op_rs2_reg        <= bus.pcpi_rs2;
      op_rs1_signed_reg <= rs1_signed;
      op_rs2_signed_reg <= rs2_signed;
      op_f3_reg         <= funct3;
    end
  end

  picorv32_mul_core #(
    .XLEN       (XLEN),
    .MUL_STAGES (MUL_STAGES)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (launch),
    .a         (rs1_ext),
    .b         (rs2_ext),
    .out_valid (core_valid),
    .product   (core_product)
  );

  // -------------------------------------------------------------- outputs
  assign bus.pcpi_ready = ready_reg;
  assign bus.pcpi_wr    = ready_reg;
  assign bus.pcpi_rd    = rd_reg;
  assign bus.stat_hit   = hit_reg;
  assign bus.pcpi_wait  = ENABLE_WAIT && (state_reg == ST_BUSY);

endmodule

// File: tb/tb_picorv32_pcpi_mul_pipe.sv
// Self-checking bench for picorv32_pcpi_mul_pipe (XLEN=32, MUL_STAGES=2).
module tb_picorv32_pcpi_mul_pipe;

  localparam logic [31:0] I_MUL    = 32'h0200_0033;
  localparam logic [31:0] I_MULH   = 32'h0200_1033;
  localparam logic [31:0] I_MULHSU = 32'h0200_2033;
  localparam logic [31:0] I_MULHU  = 32'h0200_3033;
  localparam logic [31:0] I_ADD    = 32'h0000_0033;
  localparam logic [31:0] I_DIV    = 32'h0200_4033;
  localparam int          BUDGET   = 20;

  logic clk = 1'b0;
  logic reset;

  picorv32_pcpi_mul_pipe_if #(.XLEN(32)) bus ();

  picorv32_pcpi_mul_pipe #(
    .XLEN         (32),
    .MUL_STAGES   (2),
    .ENABLE_REUSE (1'b1),
    .ENABLE_WAIT  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    bit          hit;
    int          lat;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] rd;
    bit          hit;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_wait"},  32'(bus.pcpi_wait),  32'd0);
    chk({tag, "_ready"}, 32'(bus.pcpi_ready), 32'd0);
    chk({tag, "_wr"},    32'(bus.pcpi_wr),    32'd0);
    chk({tag, "_rd"},    bus.pcpi_rd,         32'd0);
    chk({tag, "_hit"},   32'(bus.stat_hit),   32'd0);
  endtask

  // Called at posedge+1; drives the request as cycle 0 and follows it to ready.
  task automatic run_op(input int id, input logic [31:0] insn, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] exp_rd,
                        input bit exp_hit, input int exp_lat);
    exp_t e;
    exp_t x;
    bit   got;
    int   k;
    e.id = id; e.rd = exp_rd; e.hit = exp_hit; e.lat = exp_lat;
    sb.push_back(e);
    got = 1'b0;
    k   = 0;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = rs1;
    bus.pcpi_rs2   = rs2;
    bus.pcpi_valid = 1'b1;
    while (!got && k <= BUDGET) begin
      @(negedge clk);
      chk($sformatf("op%0d_wait_c%0d", id, k), 32'(bus.pcpi_wait),
          32'((k >= 1) && (k < exp_lat)));
      if (bus.pcpi_ready) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL op%0d_unexpected_ready: got ready, expected none queued", id);
        end else begin
          x = sb.pop_front();
          chk($sformatf("op%0d_latency", x.id), 32'(k), 32'(x.lat));
          chk($sformatf("op%0d_rd", x.id), bus.pcpi_rd, x.rd);
          chk($sformatf("op%0d_hit", x.id), 32'(bus.stat_hit), 32'(x.hit));
          chk($sformatf("op%0d_wr", x.id), 32'(bus.pcpi_wr), 32'd1);
          $display("op %0d insn=%h rs1=%h rs2=%h rd=%h hit=%0d cycle=%0d",
                   x.id, insn, rs1, rs2, bus.pcpi_rd, bus.stat_hit, k);
        end
      end else begin
        chk($sformatf("op%0d_rd_idle_c%0d", id, k), bus.pcpi_rd, 32'd0);
      end
      @(posedge clk);
      #1;
      if (got) bus.pcpi_valid = 1'b0;
      k++;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL op%0d_timeout: got no ready in %0d cycles, expected ready at %0d",
               id, BUDGET, exp_lat);
      bus.pcpi_valid = 1'b0;
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{I_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 3};
    vecs[1]  = '{I_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 3};
    vecs[2]  = '{I_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3};
    vecs[3]  = '{I_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 3};
    vecs[4]  = '{I_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 3};
    vecs[5]  = '{I_MULHU,  32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 1'b0, 3};
    vecs[6]  = '{I_MUL,    32'h0001_0000, 32'h0003_0000, 32'h0000_0000, 1'b1, 1};
    vecs[7]  = '{I_MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 1'b0, 3};
    vecs[8]  = '{I_MULH,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 3};
    vecs[9]  = '{I_MULH,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b1, 1};
    vecs[10] = '{I_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 3};
    vecs[11] = '{I_MUL,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1, 1};

    reset          = 1'b1;
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn  = '0;
    bus.pcpi_rs1   = '0;
    bus.pcpi_rs2   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_quiet("reset_state");
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op(i, vecs[i].insn, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].hit, vecs[i].lat);
    end

    // Abort: request withdrawn while BUSY.
    bus.pcpi_insn = I_MUL; bus.pcpi_rs1 = 32'd5; bus.pcpi_rs2 = 32'd6;
    bus.pcpi_valid = 1'b1;
    @(negedge clk);
    chk("abort_c0_wait", 32'(bus.pcpi_wait), 32'd0);
    @(posedge clk);
    #1 bus.pcpi_valid = 1'b0;
    @(negedge clk);
    chk("abort_c1_wait", 32'(bus.pcpi_wait), 32'd1);
    chk("abort_c1_ready", 32'(bus.pcpi_ready), 32'd0);
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      check_quiet($sformatf("abort_c%0d", c));
    end
    @(posedge clk);
    #1;
    $display("abort sequence finished, reissuing");
    run_op(20, I_MUL, 32'd5, 32'd6, 32'd30, 1'b0, 3);

    // Reset while BUSY: outputs clear next cycle and the cache is emptied.
    bus.pcpi_insn = I_MUL; bus.pcpi_rs1 = 32'd9; bus.pcpi_rs2 = 32'd11;
    bus.pcpi_valid = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1; bus.pcpi_valid = 1'b0;
    @(negedge clk);
    chk("rst_c1_wait", 32'(bus.pcpi_wait), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_quiet("rst_c2");
    @(posedge clk);
    #1;
    $display("mid-busy reset applied, repeating last op");
    run_op(21, I_MUL, 32'd5, 32'd6, 32'd30, 1'b0, 3);

    // Reset and a cacheable request in the same cycle: reset wins.
    bus.pcpi_insn = I_MUL; bus.pcpi_rs1 = 32'd5; bus.pcpi_rs2 = 32'd6;
    bus.pcpi_valid = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; bus.pcpi_valid = 1'b0;
    @(negedge clk);
    check_quiet("rstreq_c1");
    @(negedge clk);
    check_quiet("rstreq_c2");
    @(posedge clk);
    #1;
    $display("reset with request applied");
    run_op(22, I_MUL, 32'd5, 32'd6, 32'd30, 1'b0, 3);

    // Instructions outside the multiply group get no response.
    for (int j = 0; j < 2; j++) begin
      bus.pcpi_insn  = (j == 0) ? I_ADD : I_DIV;
      bus.pcpi_rs1   = 32'd3;
      bus.pcpi_rs2   = 32'd4;
      bus.pcpi_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check_quiet($sformatf("nonm%0d_c%0d", j, c));
        @(posedge clk);
        #1;
      end
      bus.pcpi_valid = 1'b0;
      $display("non-multiply insn=%h held for 4 cycles", bus.pcpi_insn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
